sb_param_ccff: RTL and testbench

//  Parametrised 4-sided switch block with a double-buffered configuration chain (ccff).

---
 rtl/sb_param_ccff.sv | 138 +++++++++++++
 tb/tb_sb_param_ccff.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_param_ccff.sv
// 4-sided switch block with a double-buffered serial configuration chain.
// Define SB_CFG_PARITY_EN to append an even-parity bit to the configuration stream.
module sb_param_ccff #(
    parameter int W        = 4,
    parameter int NUM_PINS = 2
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    ccff_en,
    input  logic                    ccff_head,
    input  logic                    cfg_load,
    input  logic [W-1:0]            chan_in_top,
    input  logic [W-1:0]            chan_in_right,
    input  logic [W-1:0]            chan_in_bottom,
    input  logic [W-1:0]            chan_in_left,
    input  logic [4*NUM_PINS-1:0]   pin_in,
    output logic [W-1:0]            chan_out_top,
    output logic [W-1:0]            chan_out_right,
    output logic [W-1:0]            chan_out_bottom,
    output logic [W-1:0]            chan_out_left,
    output logic                    ccff_tail,
    output logic                    cfg_valid,
    output logic                    load_err
);

    localparam int SEL_W    = $clog2(3 + NUM_PINS);
    localparam int CFG_BITS = 4 * W * SEL_W;
`ifdef SB_CFG_PARITY_EN
    localparam int LEN      = CFG_BITS + 1;
`else
    localparam int LEN      = CFG_BITS;
`endif
    localparam int CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN);

    logic [LEN-1:0]      sreg_q, sreg_d;
    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                load_err_q, load_err_d;
    logic                commit_ok;
    logic [CFG_BITS-1:0] sreg_cfg;

    // The parity bit is the last one shifted in, so it sits at sreg[0] and is dropped on commit.
`ifdef SB_CFG_PARITY_EN
    assign commit_ok = (cnt_q == CNT_FULL) && !(^sreg_q);
    assign sreg_cfg  = sreg_q[LEN-1:1];
`else
    assign commit_ok = (cnt_q == CNT_FULL);
    assign sreg_cfg  = sreg_q;
`endif

    always_comb begin
        sreg_d      = sreg_q;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        cfg_valid_d = cfg_valid_q;
        load_err_d  = load_err_q;
        if (ccff_en) begin
            sreg_d = {sreg_q[LEN-2:0], ccff_head};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A commit samples the pre-shift chain; a shift in the same cycle counts as the first new bit.
        if (cfg_load) begin
            if (commit_ok) begin
                cfg_d       = sreg_cfg;
                cfg_valid_d = 1'b1;
                cnt_d       = ccff_en ? CNT_W'(1) : '0;
            end else begin
                load_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sreg_q      <= '0;
            cfg_q       <= '0;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            load_err_q  <= load_err_d;
        end
    end

    logic [3:0][W-1:0] chan_in_all;
    logic [3:0][W-1:0] chan_out_all;

    assign chan_in_all[0] = chan_in_top;
    assign chan_in_all[1] = chan_in_right;
    assign chan_in_all[2] = chan_in_bottom;
    assign chan_in_all[3] = chan_in_left;

    for (genvar s = 0; s < 4; s++) begin : g_side
        logic [NUM_PINS-1:0] side_pins;
        assign side_pins = pin_in[s*NUM_PINS +: NUM_PINS];

        for (genvar i = 0; i < W; i++) begin : g_track
            logic [SEL_W-1:0]    sel;
            logic [NUM_PINS-1:0] pin_mask;
            logic                route;

            assign sel      = cfg_q[(s*W+i)*SEL_W +: SEL_W];
            assign pin_mask = NUM_PINS'(1) << (sel - SEL_W'(3));

            always_comb begin
                route = 1'b0;
                if (sel == SEL_W'(0)) begin
                    route = chan_in_all[(s+2)%4][i];
                end else if (sel == SEL_W'(1)) begin
                    route = chan_in_all[(s+1)%4][i];
                end else if (sel == SEL_W'(2)) begin
                    route = chan_in_all[(s+3)%4][i];
                end else if (32'(sel) < 32'(3 + NUM_PINS)) begin
                    route = |(side_pins & pin_mask);
                end
            end

            assign chan_out_all[s][i] = cfg_valid_q & route;
        end
    end

    assign chan_out_top    = chan_out_all[0];
    assign chan_out_right  = chan_out_all[1];
    assign chan_out_bottom = chan_out_all[2];
    assign chan_out_left   = chan_out_all[3];
    assign ccff_tail       = sreg_q[LEN-1];
    assign cfg_valid       = cfg_valid_q;
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_sb_param_ccff.sv
// Testbench for sb_param_ccff (W=4, NUM_PINS=2, default build without parity).
// Routing expectations come from a vector table and a scoreboard queue.
module tb_sb_param_ccff;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        ccff_en;
    logic        ccff_head;
    logic        cfg_load;
    logic [3:0]  chan_in_top, chan_in_right, chan_in_bottom, chan_in_left;
    logic [7:0]  pin_in;
    logic [3:0]  chan_out_top, chan_out_right, chan_out_bottom, chan_out_left;
    logic        ccff_tail;
    logic        cfg_valid;
    logic        load_err;

    int checks = 0;
    int passes = 0;

    logic [15:0] exp_q[$];
    logic        tail_q[$];

    typedef struct {
        string       name;
        logic [47:0] cfg;
        logic [15:0] chan_in;
        logic [7:0]  pins;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    sb_param_ccff #(.W(4), .NUM_PINS(2)) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .ccff_en         (ccff_en),
        .ccff_head       (ccff_head),
        .cfg_load        (cfg_load),
        .chan_in_top     (chan_in_top),
        .chan_in_right   (chan_in_right),
        .chan_in_bottom  (chan_in_bottom),
        .chan_in_left    (chan_in_left),
        .pin_in          (pin_in),
        .chan_out_top    (chan_out_top),
        .chan_out_right  (chan_out_right),
        .chan_out_bottom (chan_out_bottom),
        .chan_out_left   (chan_out_left),
        .ccff_tail       (ccff_tail),
        .cfg_valid       (cfg_valid),
        .load_err        (load_err)
    );

    always #5 prog_clk = ~prog_clk;

    function automatic logic [47:0] fill(input logic [2:0] sel);
        logic [47:0] r;
        for (int k = 0; k < 16; k++) r[k*3 +: 3] = sel;
        return r;
    endfunction

    function automatic logic [47:0] set_field(input logic [47:0] c, input int k, input logic [2:0] sel);
        logic [47:0] r;
        r = c;
        r[k*3 +: 3] = sel;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [47:0] cfg, input int hi, input int lo);
        for (int j = hi; j >= lo; j--) begin
            ccff_en   = 1'b1;
            ccff_head = cfg[j];
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic load_cfg();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    // Drive routing inputs and queue the routed result they should produce.
    task automatic applyStimulus(input logic [15:0] ci, input logic [7:0] p, input logic [15:0] e);
        {chan_in_top, chan_in_right, chan_in_bottom, chan_in_left} = ci;
        pin_in = p;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check_routing(input string name);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s: scoreboard empty, got %0h, expected an entry", name,
                     {chan_out_top, chan_out_right, chan_out_bottom, chan_out_left});
        end else begin
            e = exp_q.pop_front();
            checkOutput(name, {chan_out_top, chan_out_right, chan_out_bottom, chan_out_left}, e);
        end
    endtask

    initial begin
        logic [47:0] cfg_a, cfg_b, rnd, cfg_c, cfg_d;
        logic        bit_v, exp_tail;

        pReset = 1'b1; ccff_en = 1'b0; ccff_head = 1'b0; cfg_load = 1'b0;
        chan_in_top = '0; chan_in_right = '0; chan_in_bottom = '0; chan_in_left = '0; pin_in = '0;

        // Reset held while every input toggles.
        for (int c = 0; c < 4; c++) begin
            {chan_in_top, chan_in_right, chan_in_bottom, chan_in_left} = 16'($urandom) | 16'h1111;
            pin_in    = 8'($urandom);
            ccff_en   = 1'b1;
            ccff_head = 1'b1;
            cfg_load  = c[0];
            tick();
        end
        applyStimulus(16'hFFFF, 8'hFF, 16'h0000);
        check_routing("reset_chan_out");
        checkOutput("reset_tail",  16'(ccff_tail), 16'h0);
        checkOutput("reset_valid", 16'(cfg_valid), 16'h0);
        checkOutput("reset_err",   16'(load_err),  16'h0);
        ccff_en = 1'b0; ccff_head = 1'b0; cfg_load = 1'b0;
        #2 pReset = 1'b0;
        tick();
        applyStimulus(16'hFFFF, 8'hFF, 16'h0000);
        check_routing("unconfigured_forced_zero");

        vecs[0] = '{"straight",   fill(3'd0), 16'h12A5, 8'h00, 16'hA512};
        vecs[1] = '{"sel1",       fill(3'd1), 16'h12A5, 8'h00, 16'h2A51};
        vecs[2] = '{"sel2",       fill(3'd2), 16'h12A5, 8'h00, 16'h512A};
        vecs[3] = '{"pin_lo",     fill(3'd3), 16'h12A5, 8'h96, 16'h0FF0};
        vecs[4] = '{"pin_hi",     fill(3'd4), 16'h12A5, 8'h96, 16'hF00F};
        vecs[5] = '{"sel5_zero",  fill(3'd5), 16'hFFFF, 8'hFF, 16'h0000};
        vecs[6] = '{"sel7_zero",  fill(3'd7), 16'hFFFF, 8'hFF, 16'h0000};
        vecs[7] = '{"mixed_top",
                    set_field(set_field(set_field(fill(3'd0), 1, 3'd1), 2, 3'd2), 3, 3'd3),
                    16'h12A5, 8'h01, 16'hE512};

        for (int v = 0; v < 8; v++) begin
            shift_bits(vecs[v].cfg, 47, 0);
            load_cfg();
            applyStimulus(vecs[v].chan_in, vecs[v].pins, vecs[v].exp_out);
            check_routing(vecs[v].name);
            checkOutput({vecs[v].name, "_valid"}, 16'(cfg_valid), 16'h1);
            checkOutput({vecs[v].name, "_err"},   16'(load_err),  16'h0);
        end

        // Live reprogramming of a single track: old routing holds until the load edge.
        cfg_a = set_field(fill(3'd0), 2, 3'd3);
        cfg_b = set_field(fill(3'd0), 2, 3'd7);
        shift_bits(cfg_a, 47, 0);
        load_cfg();
        applyStimulus(16'h12A5, 8'h01, 16'hE512);
        check_routing("top2_pin");
        shift_bits(cfg_b, 47, 0);
        applyStimulus(16'h12A5, 8'h01, 16'hE512);
        check_routing("hold_before_load");
        load_cfg();
        applyStimulus(16'h12A5, 8'h01, 16'hA512);
        check_routing("top2_sel7");

        // Short stream is rejected; the missing bit then completes it.
        shift_bits(fill(3'd2), 47, 1);
        load_cfg();
        applyStimulus(16'h12A5, 8'h01, 16'hA512);
        check_routing("short_no_commit");
        checkOutput("short_err",   16'(load_err),  16'h1);
        checkOutput("short_valid", 16'(cfg_valid), 16'h1);
        shift_bits(fill(3'd2), 0, 0);
        load_cfg();
        applyStimulus(16'h12A5, 8'h01, 16'h512A);
        check_routing("completed_commit");

        // 96-bit pass-through, then a commit in the same cycle as a shift.
        rnd   = {16'($urandom), 32'($urandom)};
        cfg_c = fill(3'd1);
        cfg_d = fill(3'd0);
        for (int n = 0; n < 96; n++) begin
            bit_v     = (n < 48) ? rnd[47-n] : cfg_c[95-n];
            ccff_en   = 1'b1;
            ccff_head = bit_v;
            tail_q.push_back(bit_v);
            tick();
            if (tail_q.size() == 48) begin
                exp_tail = tail_q.pop_front();
                checkOutput($sformatf("tail_bit%0d", n - 47), 16'(ccff_tail), 16'(exp_tail));
            end
        end
        ccff_head = cfg_d[47];
        cfg_load  = 1'b1;
        tick();
        ccff_en = 1'b0; cfg_load = 1'b0;
        applyStimulus(16'h12A5, 8'h80, 16'h2A51);
        check_routing("same_cycle_pre_shift");
        shift_bits(cfg_d, 46, 1);
        load_cfg();
        applyStimulus(16'h12A5, 8'h80, 16'h2A51);
        check_routing("cnt_restarts_at_one");
        shift_bits(cfg_d, 0, 0);
        load_cfg();
        applyStimulus(16'h12A5, 8'h80, 16'hA512);
        check_routing("commit_after_restart");

        // Asynchronous reset mid-stream, then a clean reload.
        shift_bits(fill(3'd2), 47, 28);
        @(posedge prog_clk);
        #3 pReset = 1'b1;
        applyStimulus(16'h12A5, 8'h00, 16'h0000);
        check_routing("midshift_reset_out");
        checkOutput("midshift_reset_valid", 16'(cfg_valid), 16'h0);
        checkOutput("midshift_reset_err",   16'(load_err),  16'h0);
        checkOutput("midshift_reset_tail",  16'(ccff_tail), 16'h0);
        #2 pReset = 1'b0;
        tick();
        shift_bits(fill(3'd2), 47, 0);
        load_cfg();
        applyStimulus(16'h12A5, 8'h00, 16'h512A);
        check_routing("reload_after_reset");
        checkOutput("reload_valid", 16'(cfg_valid), 16'h1);
        checkOutput("reload_err",   16'(load_err),  16'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
